vstu_burst_gen: RTL and testbench

// Unit-stride store burst generator. Sits directly upstream of the vector store unit.

---
 rtl/vstu_burst_gen_pkg.sv | 25 ++
 rtl/vstu_burst_calc.sv | 44 ++++
 rtl/vstu_burst_gen.sv | 161 ++++++++++++++++
 tb/tb_vstu_burst_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vstu_burst_gen_pkg.sv
// Shared types for the unit-stride store burst generator: the burst descriptor
// handed to the store unit, the AXI size/burst encodings and the FSM state type.
package vstu_burst_gen_pkg;

  localparam int unsigned PkgAddrWidth = 64;

  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;

  localparam burst_t BURST_INCR = 2'b01;

  // Burst descriptor telling the store unit how to pack the W beats.
  typedef struct packed {
    logic [PkgAddrWidth-1:0] addr;
    logic [7:0]              len;
    size_t                   size;
    logic                    is_load;
  } addrgen_axi_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } vstu_bgen_state_e;

endpackage

// File: rtl/vstu_burst_calc.sv
// Combinational sizing of the next burst from the current address and the
// remaining byte count. A burst is limited by the remaining bytes, the next
// 4 KiB boundary and MaxBurstLen beats counted from the aligned beat base.
// Ports:
//   page_off_i  address bits [11:0] of the burst start
//   rem_i       bytes still to be stored (non-zero while issuing)
//   bb_o        bytes covered by this burst
//   len_o       AXI len (beats-1)
//   split4k_o   burst was cut short by the 4 KiB boundary
module vstu_burst_calc #(
  parameter int unsigned BeatBytes   = 16,
  parameter int unsigned MaxBurstLen = 256,
  parameter int unsigned NBytesWidth = 32
) (
  input  logic [11:0]            page_off_i,
  input  logic [NBytesWidth-1:0] rem_i,
  output logic [NBytesWidth-1:0] bb_o,
  output logic [7:0]             len_o,
  output logic                   split4k_o
);

  localparam int unsigned OffW  = $clog2(BeatBytes);
  localparam int unsigned CapW  = $clog2(MaxBurstLen * BeatBytes) + 1;
  localparam int unsigned BaseW = (NBytesWidth > CapW) ? NBytesWidth : CapW;
  // One spare bit above every operand so off+bb+BeatBytes-1 cannot overflow.
  localparam int unsigned WideW = ((BaseW > 13) ? BaseW : 13) + 1;

  logic [WideW-1:0] off_w, to4k_w, cap_w, rem_w, bb_w, beats_w;

  always_comb begin
    off_w   = WideW'(page_off_i[OffW-1:0]);
    to4k_w  = WideW'(4096) - WideW'(page_off_i);
    cap_w   = WideW'(MaxBurstLen * BeatBytes) - off_w;
    rem_w   = WideW'(rem_i);
    bb_w    = rem_w;
    if (to4k_w < bb_w) bb_w = to4k_w;
    if (cap_w < bb_w)  bb_w = cap_w;
    beats_w = (off_w + bb_w + WideW'(BeatBytes - 1)) >> OffW;
    len_o     = 8'(beats_w - WideW'(1));
    bb_o      = NBytesWidth'(bb_w);
    split4k_o = (bb_w == to4k_w) && (to4k_w < rem_w);
  end

endmodule

// File: rtl/vstu_burst_gen.sv
// Unit-stride store burst generator. Splits one store request into AXI INCR
// bursts (MaxBurstLen and 4 KiB limited) and forks each burst onto the AW
// channel and the store-unit descriptor channel.
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   req_addr_i/nbytes_i/valid_i  store request; req_ready_o high in IDLE
//   aw_*_o / aw_ready_i          AXI write address channel
//   addrgen_req_o/valid_o/ready_i burst descriptor for the store unit
//   busy_o                       request in progress
// Optional: define VSTU_BURST_PERF_EN to add perf_bursts_o (completed bursts)
// and perf_splits4k_o (bursts cut by a 4 KiB boundary).
module vstu_burst_gen
  import vstu_burst_gen_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned MaxBurstLen  = 256,
  parameter int unsigned NBytesWidth  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [NBytesWidth-1:0]  req_nbytes_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic [AxiAddrWidth-1:0] aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output addrgen_axi_req_t        addrgen_req_o,
  output logic                    addrgen_valid_o,
  input  logic                    addrgen_ready_i,
  output logic                    busy_o
`ifdef VSTU_BURST_PERF_EN
  ,
  output logic [31:0]             perf_bursts_o,
  output logic [31:0]             perf_splits4k_o
`endif
);

  localparam int unsigned BeatBytes = AxiDataWidth / 8;
  localparam size_t       BeatSize  = 3'($clog2(BeatBytes));

  vstu_bgen_state_e        state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [NBytesWidth-1:0]  rem_q, rem_d;
  logic                    aw_sent_q, aw_sent_d;
  logic                    ag_sent_q, ag_sent_d;

  logic [NBytesWidth-1:0]  bb;
  logic [7:0]              len;
  logic                    split4k;
  logic                    fork_done_c;

  vstu_burst_calc #(
    .BeatBytes   (BeatBytes),
    .MaxBurstLen (MaxBurstLen),
    .NBytesWidth (NBytesWidth)
  ) i_calc (
    .page_off_i (addr_q[11:0]),
    .rem_i      (rem_q),
    .bb_o       (bb),
    .len_o      (len),
    .split4k_o  (split4k)
  );

  // Outputs decode flops only; addr_q/rem_q hold until both handshakes are
  // done, so the presented burst stays stable while any valid is high.
  assign req_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q == ISSUE);
  assign aw_valid_o      = busy_o && !aw_sent_q;
  assign addrgen_valid_o = busy_o && !ag_sent_q;
  assign aw_addr_o       = addr_q;
  assign aw_len_o        = len;
  assign aw_size_o       = BeatSize;
  assign aw_burst_o      = BURST_INCR;

  always_comb begin
    addrgen_req_o         = '0;
    addrgen_req_o.addr    = PkgAddrWidth'(addr_q);
    addrgen_req_o.len     = len;
    addrgen_req_o.size    = BeatSize;
    addrgen_req_o.is_load = 1'b0;
  end

  // Next state: request capture and the AW/addrgen fork.
  always_comb begin
    logic aw_done, ag_done;
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    aw_sent_d   = aw_sent_q;
    ag_sent_d   = ag_sent_q;
    fork_done_c = 1'b0;
    aw_done     = aw_sent_q || (aw_valid_o && aw_ready_i);
    ag_done     = ag_sent_q || (addrgen_valid_o && addrgen_ready_i);
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          rem_d  = req_nbytes_i;
          if (req_nbytes_i != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (aw_done && ag_done) begin
          fork_done_c = 1'b1;
          addr_d      = addr_q + AxiAddrWidth'(bb);
          rem_d       = rem_q - bb;
          aw_sent_d   = 1'b0;
          ag_sent_d   = 1'b0;
          if (rem_q == bb) state_d = IDLE;
        end else begin
          aw_sent_d = aw_done;
          ag_sent_d = ag_done;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      aw_sent_q <= 1'b0;
      ag_sent_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      aw_sent_q <= aw_sent_d;
      ag_sent_q <= ag_sent_d;
    end
  end

`ifdef VSTU_BURST_PERF_EN
  logic [31:0] perf_bursts_q, perf_splits4k_q;

  // Free-running wrap-around counters of completed forks and 4 KiB splits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_bursts_q   <= '0;
      perf_splits4k_q <= '0;
    end else if (fork_done_c) begin
      perf_bursts_q <= perf_bursts_q + 32'd1;
      if (split4k) perf_splits4k_q <= perf_splits4k_q + 32'd1;
    end
  end

  assign perf_bursts_o   = perf_bursts_q;
  assign perf_splits4k_o = perf_splits4k_q;
`else
  logic unused_split4k;
  assign unused_split4k = split4k;
`endif

endmodule

// File: tb/tb_vstu_burst_gen.sv
// Bench for vstu_burst_gen: directed scenarios plus randomized requests with
// random ready back-pressure, checked against a byte-level burst model.
module tb_vstu_burst_gen;
  import vstu_burst_gen_pkg::*;

  localparam int unsigned AW  = 64;
  localparam int unsigned NBW = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [AW-1:0]    req_addr_i;
  logic [NBW-1:0]   req_nbytes_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [AW-1:0]    aw_addr_o;
  logic [7:0]       aw_len_o;
  logic [2:0]       aw_size_o;
  logic [1:0]       aw_burst_o;
  logic             aw_valid_o;
  logic             aw_ready_i;
  addrgen_axi_req_t addrgen_req_o;
  logic             addrgen_valid_o;
  logic             addrgen_ready_i;
  logic             busy_o;
`ifdef VSTU_BURST_PERF_EN
  logic [31:0]      perf_bursts_o, perf_splits4k_o;
`endif

  vstu_burst_gen dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_addr_i      (req_addr_i),
    .req_nbytes_i    (req_nbytes_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .aw_addr_o       (aw_addr_o),
    .aw_len_o        (aw_len_o),
    .aw_size_o       (aw_size_o),
    .aw_burst_o      (aw_burst_o),
    .aw_valid_o      (aw_valid_o),
    .aw_ready_i      (aw_ready_i),
    .addrgen_req_o   (addrgen_req_o),
    .addrgen_valid_o (addrgen_valid_o),
    .addrgen_ready_i (addrgen_ready_i),
    .busy_o          (busy_o)
`ifdef VSTU_BURST_PERF_EN
    ,
    .perf_bursts_o   (perf_bursts_o),
    .perf_splits4k_o (perf_splits4k_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_chk  = 0;

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  typedef struct {
    longint unsigned addr;
    int unsigned     len;
  } burst_t;

  burst_t aw_exp[$];
  burst_t ag_exp[$];

  // Reference: walk the byte range, cutting at 4 KiB pages and 256 beats of 16 B.
  task automatic model_push(longint unsigned addr, longint unsigned nbytes);
    longint unsigned a = addr, r = nbytes, off, to4k, cap, bb;
    burst_t b;
    while (r > 0) begin
      off  = a % 16;
      to4k = 4096 - (a % 4096);
      cap  = 256 * 16 - off;
      bb   = r;
      if (to4k < bb) bb = to4k;
      if (cap < bb)  bb = cap;
      b.addr = a;
      b.len  = int'((off + bb + 15) / 16 - 1);
      aw_exp.push_back(b);
      ag_exp.push_back(b);
      a += bb;
      r -= bb;
    end
  endtask

  // Monitor: pop on each handshake about to happen; check stability while stalled.
  logic            aw_pend = 1'b0, ag_pend = 1'b0;
  longint unsigned aw_paddr, ag_paddr;
  int unsigned     aw_plen, ag_plen;

  always @(negedge clk_i) begin
    burst_t e;
    if (!rst_ni) begin
      aw_pend = 1'b0;
      ag_pend = 1'b0;
    end else begin
      if (aw_pend) begin
        check("aw_hold_valid", aw_valid_o, 1);
        check("aw_hold_addr", aw_addr_o, aw_paddr);
        check("aw_hold_len", aw_len_o, aw_plen);
      end
      if (ag_pend) begin
        check("ag_hold_valid", addrgen_valid_o, 1);
        check("ag_hold_addr", addrgen_req_o.addr, ag_paddr);
        check("ag_hold_len", addrgen_req_o.len, ag_plen);
      end
      if (aw_valid_o && aw_ready_i) begin
        if (aw_exp.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          e = aw_exp.pop_front();
          check("aw_addr", aw_addr_o, e.addr);
          check("aw_len", aw_len_o, e.len);
          check("aw_size", aw_size_o, 4);
          check("aw_burst", aw_burst_o, 1);
        end
      end
      if (addrgen_valid_o && addrgen_ready_i) begin
        if (ag_exp.size() == 0) check("ag_unexpected", 1, 0);
        else begin
          e = ag_exp.pop_front();
          check("ag_addr", addrgen_req_o.addr, e.addr);
          check("ag_len", addrgen_req_o.len, e.len);
          check("ag_size", addrgen_req_o.size, 4);
          check("ag_is_load", addrgen_req_o.is_load, 0);
        end
      end
      aw_pend  = aw_valid_o && !aw_ready_i;
      ag_pend  = addrgen_valid_o && !addrgen_ready_i;
      aw_paddr = aw_addr_o;
      aw_plen  = aw_len_o;
      ag_paddr = addrgen_req_o.addr;
      ag_plen  = addrgen_req_o.len;
    end
  end

  // Random back-pressure when enabled.
  logic rand_ready = 1'b0;
  always @(posedge clk_i) begin
    if (rand_ready) begin
      #1;
      aw_ready_i      = ($urandom_range(0, 2) != 0);
      addrgen_ready_i = ($urandom_range(0, 2) != 0);
    end
  end

  // Present a request and drop it right after the accepting edge.
  task automatic do_req(longint unsigned addr, longint unsigned nbytes);
    int cyc = 0;
    @(posedge clk_i);
    #1;
    req_addr_i   = AW'(addr);
    req_nbytes_i = NBW'(nbytes);
    req_valid_i  = 1'b1;
    model_push(addr, nbytes);
    @(negedge clk_i);
    while (!req_ready_o && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 5000) check("req_accept_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int cyc = 0;
    @(negedge clk_i);
    while (!(!busy_o && req_ready_o && aw_exp.size() == 0 && ag_exp.size() == 0) && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
    end
    if (cyc >= 5000) check({name, "_idle_timeout"}, 0, 1);
  endtask

  initial begin
    longint unsigned a, n;
    rst_ni          = 1'b0;
    req_addr_i      = '0;
    req_nbytes_i    = '0;
    req_valid_i     = 1'b0;
    aw_ready_i      = 1'b0;
    addrgen_ready_i = 1'b0;

    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_aw_valid", aw_valid_o, 0);
    check("rst_ag_valid", addrgen_valid_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Single burst: ISSUE one cycle, back to IDLE on the next.
    aw_ready_i = 1'b1;
    addrgen_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_addr_i = 64'h1000; req_nbytes_i = 64; req_valid_i = 1'b1;
    model_push(64'h1000, 64);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("t1_busy", busy_o, 1);
    check("t1_aw_valid", aw_valid_o, 1);
    @(negedge clk_i);
    check("t1_idle_ready", req_ready_o, 1);
    check("t1_idle_busy", busy_o, 0);
    wait_idle("t1");

    // Page crossing: 8 bytes then 24 bytes.
    do_req(64'h0FF8, 32);
    wait_idle("t2");

    // Two full bursts back to back.
    do_req(64'h0, 8192);
    wait_idle("t3");

    // AW accepted at once, descriptor stalled for five cycles.
    addrgen_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    req_addr_i = 64'h0FF8; req_nbytes_i = 32; req_valid_i = 1'b1;
    model_push(64'h0FF8, 32);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("t4_aw_valid_first", aw_valid_o, 1);
    check("t4_ag_valid_first", addrgen_valid_o, 1);
    repeat (4) begin
      @(negedge clk_i);
      check("t4_aw_dropped", aw_valid_o, 0);
      check("t4_ag_held", addrgen_valid_o, 1);
      check("t4_ag_addr", addrgen_req_o.addr, 64'h0FF8);
    end
    @(posedge clk_i);
    #1;
    addrgen_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t4_next_aw_valid", aw_valid_o, 1);
    check("t4_next_aw_addr", aw_addr_o, 64'h1000);
    wait_idle("t4");

    // Zero-length request: accepted, nothing issued.
    @(negedge clk_i);
    check("t5_ready_before", req_ready_o, 1);
    do_req(64'h2340, 0);
    repeat (3) begin
      @(negedge clk_i);
      check("t5_no_aw", aw_valid_o, 0);
      check("t5_no_ag", addrgen_valid_o, 0);
      check("t5_ready", req_ready_o, 1);
    end

    // Reset while the second 4 KiB burst is presented.
    @(posedge clk_i);
    #1;
    req_addr_i = 64'h0; req_nbytes_i = 8192; req_valid_i = 1'b1;
    model_push(64'h0, 8192);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t6_burst2_addr", aw_addr_o, 64'h1000);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_aw_valid", aw_valid_o, 0);
    check("t6_rst_ag_valid", addrgen_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    aw_exp.delete();
    ag_exp.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t6_ready_after", req_ready_o, 1);
    check("t6_busy_after", busy_o, 0);

    // Randomized requests under random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = longint'($urandom_range(0, 15)) << 12;
      if ($urandom_range(0, 1) != 0) a += 4096 - longint'($urandom_range(1, 64));
      else                           a += longint'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       n = 0;
        1:       n = longint'($urandom_range(1, 64));
        default: n = longint'($urandom_range(1, 10000));
      endcase
      do_req(a, n);
      wait_idle("rand");
    end
    rand_ready = 1'b0;

    check("final_aw_queue", aw_exp.size(), 0);
    check("final_ag_queue", ag_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
